// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared pointer helpers and types for the single-port FIFO
//               controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_MAX_AW = 16;

    // Pointer layout: wrap bit above the RAM address.
    typedef struct packed {
        logic                wrap;
        logic [c_MAX_AW-1:0] addr;
    } fifo_ptr_t;

    function automatic int f_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Modular pointer distance; only the low ptr_w bits are meaningful.
    function automatic logic [31:0] f_occupancy(
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr,
        input int          ptr_w
    );
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_out_reg.sv
// ============================================================================
// Module      : fifo_out_reg
// Description : Registered output stage; loads a word from the async-read RAM
//               whenever the stage is free or being drained.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_out_reg
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    input  logic                  i_ready,
    output logic                  o_load,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid_q;
    logic                  w_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [DATA_WIDTH-1:0] w_data_d;
    logic                  w_load;

    assign w_load = ~i_empty & (~r_valid_q | i_ready) & ~i_flush & ~rst;

    always_comb begin
        w_valid_d = r_valid_q;
        w_data_d  = r_data_q;
        if (i_flush) begin
            w_valid_d = 1'b0;
        end else if (w_load) begin
            w_valid_d = 1'b1;
            w_data_d  = i_ram_data;
        end else if (r_valid_q && i_ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
        end
    end

    assign o_load  = w_load;
    assign o_valid = r_valid_q;
    assign o_data  = r_data_q;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl_sp.sv
// ============================================================================
// Module      : fifo_ctrl_sp
// Description : FIFO controller for an external async-read / sync-write RAM;
//               owns pointers, occupancy, full/empty and flush.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_ctrl_sp
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [AW+1:0]         o_level,
    output logic                  o_ram_wr_en,
    output logic [AW-1:0]         o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_rd_en,
    output logic [AW-1:0]         o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    localparam int            PW         = f_ptr_width(DEPTH);
    localparam logic [PW-1:0] c_full_occ = PW'(DEPTH);
    localparam logic [PW-1:0] c_ptr_one  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] r_wr_ptr_q;
    logic [PW-1:0] w_wr_ptr_d;
    logic [PW-1:0] r_rd_ptr_q;
    logic [PW-1:0] w_rd_ptr_d;
    logic [PW-1:0] w_occ;
    logic          w_full;
    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_load;
    logic          w_valid;

    assign w_occ   = PW'(f_occupancy(32'(r_wr_ptr_q), 32'(r_rd_ptr_q), PW));
    assign w_full  = (w_occ == c_full_occ);
    assign w_empty = (w_occ == '0);

    // Full is judged on registered occupancy; a same-cycle load frees space next cycle.
    assign w_ready = ~w_full & ~rst & ~i_flush;
    assign w_push  = i_valid & w_ready;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end else begin
            if (w_push) w_wr_ptr_d = r_wr_ptr_q + c_ptr_one;
            if (w_load) w_rd_ptr_d = r_rd_ptr_q + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    fifo_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_empty    (w_empty),
        .i_ram_data (i_ram_data),
        .i_ready    (i_ready),
        .o_load     (w_load),
        .o_valid    (w_valid),
        .o_data     (o_data)
    );

    assign o_ready       = w_ready;
    assign o_valid       = w_valid;
    assign o_level       = {1'b0, w_occ} + {{PW{1'b0}}, w_valid};
    assign o_ram_wr_en   = w_push;
    assign o_ram_wr_addr = r_wr_ptr_q[AW-1:0];
    assign o_ram_data    = i_data;
    assign o_ram_rd_en   = w_load;
    assign o_ram_rd_addr = r_rd_ptr_q[AW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl_sp.sv
// ============================================================================
// Module      : tb_fifo_ctrl_sp
// Description : Directed self-checking bench for fifo_ctrl_sp with a
//               behavioural async-read / sync-write RAM attached.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_ctrl_sp;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [AW+1:0] o_level;
    logic          o_ram_wr_en;
    logic [AW-1:0] o_ram_wr_addr;
    logic [DW-1:0] o_ram_data;
    logic          o_ram_rd_en;
    logic [AW-1:0] o_ram_rd_addr;
    logic [DW-1:0] i_ram_data;

    logic [DW-1:0] mem [DP];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ram_wr_en) mem[o_ram_wr_addr] <= o_ram_data;
    end
    assign i_ram_data = mem[o_ram_rd_addr];

    fifo_ctrl_sp #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_level       (o_level),
        .o_ram_wr_en   (o_ram_wr_en),
        .o_ram_wr_addr (o_ram_wr_addr),
        .o_ram_data    (o_ram_data),
        .o_ram_rd_en   (o_ram_rd_en),
        .o_ram_rd_addr (o_ram_rd_addr),
        .i_ram_data    (i_ram_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b0; i_data = 8'hEE;
        tick(); tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
        checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", o_level); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_ready); end
        checks++; if (o_ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", o_ram_wr_en); end
        i_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", o_ready); end
    endtask

    task automatic test_single();
        i_ready = 1'b1; i_valid = 1'b1; i_data = 8'hA1;
        #1;
        checks++; if (o_ram_wr_en !== 1'b1 || o_ram_wr_addr !== 2'd0) begin
            errors++; $display("FAIL single_write got en=%b addr=%0d want en=1 addr=0", o_ram_wr_en, o_ram_wr_addr); end
        tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_level !== 4'd1) begin
            errors++; $display("FAIL single_edge1 got valid=%b level=%0d want valid=0 level=1", o_valid, o_level); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_data !== 8'hA1 || o_level !== 4'd1) begin
            errors++; $display("FAIL single_edge2 got valid=%b data=%h level=%0d want 1 a1 1", o_valid, o_data, o_level); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_level !== 4'd0) begin
            errors++; $display("FAIL single_pop got valid=%b level=%0d want 0 0", o_valid, o_level); end
    endtask

    task automatic test_fill();
        i_ready = 1'b0; i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_data = 8'h10 + 8'(i);
            tick();
        end
        checks++; if (o_level !== 4'd5) begin errors++; $display("FAIL fill_level got %0d want 5", o_level); end
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h10) begin
            errors++; $display("FAIL fill_head got valid=%b data=%h want 1 10", o_valid, o_data); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", o_ready); end
        i_data = 8'h15;
        #1;
        checks++; if (o_ram_wr_en !== 1'b0) begin errors++; $display("FAIL fill_overflow_wr got %b want 0", o_ram_wr_en); end
        tick();
        checks++; if (o_level !== 4'd5) begin errors++; $display("FAIL fill_level_hold got %0d want 5", o_level); end
    endtask

    task automatic test_drain_wrap();
        logic [DW-1:0] push_d;
        push_d  = 8'h15;
        i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1;
            i_data  = push_d;
            #1;
            checks++; if (o_valid !== 1'b1 || o_data !== 8'h10 + 8'(c)) begin
                errors++; $display("FAIL stream_out[%0d] got valid=%b data=%h want 1 %h", c, o_valid, o_data, 8'h10 + 8'(c)); end
            checks++; if (o_ready !== (c != 0)) begin
                errors++; $display("FAIL stream_ready[%0d] got %b want %b", c, o_ready, (c != 0)); end
            tick();
            if (c != 0) push_d = push_d + 8'h01;
        end
        i_valid = 1'b0;
        checks++; if (o_level !== 4'd4) begin errors++; $display("FAIL stream_level got %0d want 4", o_level); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_data !== 8'h1A + 8'(k)) begin
                errors++; $display("FAIL drain_out[%0d] got %h want %h", k, o_data, 8'h1A + 8'(k)); end
            tick();
        end
    endtask

    task automatic test_hold_and_pop();
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (o_valid !== 1'b1 || o_data !== 8'h1D || o_level !== 4'd1) begin
                errors++; $display("FAIL hold[%0d] got valid=%b data=%h level=%0d want 1 1d 1", k, o_valid, o_data, o_level); end
        end
        i_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0 || o_level !== 4'd0 || o_data !== 8'h1D) begin
            errors++; $display("FAIL empty_pop got valid=%b level=%0d data=%h want 0 0 1d", o_valid, o_level, o_data); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'h30 + 8'(i);
            tick();
        end
        checks++; if (o_level !== 4'd3) begin errors++; $display("FAIL flush_pre_level got %0d want 3", o_level); end
        i_data = 8'h33; i_flush = 1'b1;
        #1;
        checks++; if (o_ram_wr_en !== 1'b0 || o_ready !== 1'b0 || o_ram_rd_en !== 1'b0) begin
            errors++; $display("FAIL flush_suppress got wr=%b ready=%b rd=%b want 0 0 0", o_ram_wr_en, o_ready, o_ram_rd_en); end
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_level !== 4'd0 || o_data !== 8'h30) begin
            errors++; $display("FAIL flush_after got valid=%b level=%0d data=%h want 0 0 30", o_valid, o_level, o_data); end
    endtask

    task automatic test_rst_mid();
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 8'h40; tick();
        i_data = 8'h41; tick();
        i_valid = 1'b0;
        checks++; if (o_level !== 4'd2) begin errors++; $display("FAIL rstmid_pre_level got %0d want 2", o_level); end
        rst = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_data !== 8'h00 || o_level !== 4'd0) begin
            errors++; $display("FAIL rstmid_after got valid=%b data=%h level=%0d want 0 00 0", o_valid, o_data, o_level); end
        rst = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got %b want 1", o_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain_wrap();
        test_hold_and_pop();
        test_flush();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
